// File: rtl/butterfly_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its forwarding muxes.
// The registered-field struct is sized by the package widths, so instances should keep those defaults.
package butterfly_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int STALL_CW = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        alu_op_e           alu_op;
        logic              src_a_pc;
        logic              src_b_imm;
        logic [REG_AW-1:0] rd_addr;
        logic              rd_we;
    } id_ex_t;

    // All-zero image also encodes alu_op = ALU_ADD.
    localparam id_ex_t ID_EX_RESET = '0;

    // A producer feeds a source only if it writes, the indices agree, and the source is not x0.
    function automatic logic rd_match(input logic              we,
                                      input logic [REG_AW-1:0] rd_addr,
                                      input logic [REG_AW-1:0] rs_addr);
        return we && (rd_addr == rs_addr) && (rs_addr != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass mux: x0 forces zero, then EX/MEM, then MEM/WB, else the stored register data.
module fwd_mux
    import butterfly_pkg::*;
#(
    parameter int XLEN   = butterfly_pkg::XLEN,
    parameter int REG_AW = butterfly_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic [REG_AW-1:0] exm_rd_addr_i,
    input  logic              exm_rd_we_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic [REG_AW-1:0] mwb_rd_addr_i,
    input  logic              mwb_rd_we_i,
    input  logic [XLEN-1:0]   mwb_result_i,
    output logic [XLEN-1:0]   fwd_data_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives the output; a missing branch would infer a latch.
        fwd_data_o = rs_data_i;
        if (rs_addr_i == '0) begin
            fwd_data_o = '0;
        end else if (rd_match(exm_rd_we_i, exm_rd_addr_i, rs_addr_i)) begin
            fwd_data_o = exm_result_i;
        end else if (rd_match(mwb_rd_we_i, mwb_rd_addr_i, rs_addr_i)) begin
            fwd_data_o = mwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: valid/ready capture, stall hold with MEM/WB refresh,
// combinational EX/MEM and MEM/WB bypass on the operands, and a saturating stall counter.
module id_ex_stage
    import butterfly_pkg::*;
#(
    parameter int XLEN     = butterfly_pkg::XLEN,
    parameter int REG_AW   = butterfly_pkg::REG_AW,
    parameter int STALL_CW = butterfly_pkg::STALL_CW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    output logic                id_ready_o,
    input  logic [XLEN-1:0]     id_pc_i,
    input  logic [REG_AW-1:0]   id_rs1_addr_i,
    input  logic [REG_AW-1:0]   id_rs2_addr_i,
    input  logic [XLEN-1:0]     id_rs1_data_i,
    input  logic [XLEN-1:0]     id_rs2_data_i,
    input  logic [XLEN-1:0]     id_imm_i,
    input  logic [3:0]          id_alu_op_i,
    input  logic                id_src_a_pc_i,
    input  logic                id_src_b_imm_i,
    input  logic [REG_AW-1:0]   id_rd_addr_i,
    input  logic                id_rd_we_i,
    input  logic [REG_AW-1:0]   exm_rd_addr_i,
    input  logic                exm_rd_we_i,
    input  logic [XLEN-1:0]     exm_result_i,
    input  logic [REG_AW-1:0]   mwb_rd_addr_i,
    input  logic                mwb_rd_we_i,
    input  logic [XLEN-1:0]     mwb_result_i,
    input  logic                ex_ready_i,
    input  logic                flush_i,
    output logic                ex_valid_o,
    output logic [XLEN-1:0]     operand_a_o,
    output logic [XLEN-1:0]     operand_b_o,
    output logic [3:0]          alu_op_o,
    output logic [XLEN-1:0]     ex_pc_o,
    output logic [XLEN-1:0]     ex_store_data_o,
    output logic [REG_AW-1:0]   ex_rd_addr_o,
    output logic                ex_rd_we_o,
    output logic [STALL_CW-1:0] stall_cnt_o
);

    localparam logic [STALL_CW-1:0] CNT_ONE = STALL_CW'(1);

    logic                r_valid;
    id_ex_t              r_q;
    logic [STALL_CW-1:0] r_stall_cnt;

    id_ex_t              w_id_fields;
    logic                w_hold;
    logic                w_capture;
    logic [XLEN-1:0]     w_fwd_rs1;
    logic [XLEN-1:0]     w_fwd_rs2;

    assign id_ready_o = !r_valid || ex_ready_i;
    assign w_hold     = r_valid && !ex_ready_i;
    // A flushed capture is dropped outright, so the held fields are left untouched.
    assign w_capture  = id_valid_i && id_ready_o && !flush_i;

    assign w_id_fields = '{
        pc:        id_pc_i,
        rs1_addr:  id_rs1_addr_i,
        rs2_addr:  id_rs2_addr_i,
        rs1_data:  id_rs1_data_i,
        rs2_data:  id_rs2_data_i,
        imm:       id_imm_i,
        alu_op:    alu_op_e'(id_alu_op_i),
        src_a_pc:  id_src_a_pc_i,
        src_b_imm: id_src_b_imm_i,
        rd_addr:   id_rd_addr_i,
        rd_we:     id_rd_we_i
    };

    always_ff @(posedge clk_i) begin
        // NOTE: reset is tested inside the clocked block (synchronous); all state uses non-blocking assignments.
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_q         <= ID_EX_RESET;
            r_stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (id_ready_o) begin
                r_valid <= id_valid_i;
            end

            // While stalled, a retiring MEM/WB producer would otherwise be lost before EX consumes us.
            if (w_capture) begin
                r_q <= w_id_fields;
            end else if (w_hold) begin
                if (rd_match(mwb_rd_we_i, mwb_rd_addr_i, r_q.rs1_addr)) begin
                    r_q.rs1_data <= mwb_result_i;
                end
                if (rd_match(mwb_rd_we_i, mwb_rd_addr_i, r_q.rs2_addr)) begin
                    r_q.rs2_data <= mwb_result_i;
                end
            end

            if (w_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr_i     (r_q.rs1_addr),
        .rs_data_i     (r_q.rs1_data),
        .exm_rd_addr_i (exm_rd_addr_i),
        .exm_rd_we_i   (exm_rd_we_i),
        .exm_result_i  (exm_result_i),
        .mwb_rd_addr_i (mwb_rd_addr_i),
        .mwb_rd_we_i   (mwb_rd_we_i),
        .mwb_result_i  (mwb_result_i),
        .fwd_data_o    (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr_i     (r_q.rs2_addr),
        .rs_data_i     (r_q.rs2_data),
        .exm_rd_addr_i (exm_rd_addr_i),
        .exm_rd_we_i   (exm_rd_we_i),
        .exm_result_i  (exm_result_i),
        .mwb_rd_addr_i (mwb_rd_addr_i),
        .mwb_rd_we_i   (mwb_rd_we_i),
        .mwb_result_i  (mwb_result_i),
        .fwd_data_o    (w_fwd_rs2)
    );

    assign ex_valid_o      = r_valid;
    assign operand_a_o     = r_q.src_a_pc  ? r_q.pc  : w_fwd_rs1;
    assign operand_b_o     = r_q.src_b_imm ? r_q.imm : w_fwd_rs2;
    assign alu_op_o        = r_q.alu_op;
    assign ex_pc_o         = r_q.pc;
    assign ex_store_data_o = w_fwd_rs2;
    assign ex_rd_addr_o    = r_q.rd_addr;
    assign ex_rd_we_o      = r_q.rd_we && r_valid;
    assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 2-bit stall counter shares all inputs.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [3:0]  id_alu_op_i;
    logic        id_src_a_pc_i, id_src_b_imm_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    logic [4:0]  exm_rd_addr_i, mwb_rd_addr_i;
    logic        exm_rd_we_i, mwb_rd_we_i;
    logic [31:0] exm_result_i, mwb_result_i;
    logic        ex_ready_i, flush_i;

    logic        id_ready_o, ex_valid_o, ex_rd_we_o;
    logic [31:0] operand_a_o, operand_b_o, ex_pc_o, ex_store_data_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  ex_rd_addr_o;
    logic [15:0] stall_cnt_o;

    logic        s_id_ready, s_ex_valid, s_rd_we;
    logic [31:0] s_op_a, s_op_b, s_pc, s_store;
    logic [3:0]  s_alu_op;
    logic [4:0]  s_rd_addr;
    logic [1:0]  s_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_src_a_pc_i(id_src_a_pc_i), .id_src_b_imm_i(id_src_b_imm_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i),
        .exm_rd_addr_i(exm_rd_addr_i), .exm_rd_we_i(exm_rd_we_i), .exm_result_i(exm_result_i),
        .mwb_rd_addr_i(mwb_rd_addr_i), .mwb_rd_we_i(mwb_rd_we_i), .mwb_result_i(mwb_result_i),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .alu_op_o(alu_op_o),
        .ex_pc_o(ex_pc_o), .ex_store_data_o(ex_store_data_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rd_we_o(ex_rd_we_o), .stall_cnt_o(stall_cnt_o)
    );

    id_ex_stage #(.STALL_CW(2)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_ready_o(s_id_ready),
        .id_pc_i(id_pc_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_src_a_pc_i(id_src_a_pc_i), .id_src_b_imm_i(id_src_b_imm_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i),
        .exm_rd_addr_i(exm_rd_addr_i), .exm_rd_we_i(exm_rd_we_i), .exm_result_i(exm_result_i),
        .mwb_rd_addr_i(mwb_rd_addr_i), .mwb_rd_we_i(mwb_rd_we_i), .mwb_result_i(mwb_result_i),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i), .ex_valid_o(s_ex_valid),
        .operand_a_o(s_op_a), .operand_b_o(s_op_b), .alu_op_o(s_alu_op),
        .ex_pc_o(s_pc), .ex_store_data_o(s_store), .ex_rd_addr_o(s_rd_addr),
        .ex_rd_we_o(s_rd_we), .stall_cnt_o(s_stall_cnt)
    );

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                          input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [3:0] op, input logic sa, input logic sb,
                          input logic [4:0] rd, input logic we);
        id_valid_i = 1'b1;
        id_pc_i = pc; id_rs1_addr_i = rs1a; id_rs2_addr_i = rs2a;
        id_rs1_data_i = rs1d; id_rs2_data_i = rs2d; id_imm_i = imm;
        id_alu_op_i = op; id_src_a_pc_i = sa; id_src_b_imm_i = sb;
        id_rd_addr_i = rd; id_rd_we_i = we;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        id_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
        exm_rd_we_i = 1'b0; mwb_rd_we_i = 1'b0;
        step(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(1);
        n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ex_valid_o); end
        n_vec++; if (alu_op_o !== 4'd0) begin n_err++; $display("FAIL reset_alu_op: got %0d want 0", alu_op_o); end
        n_vec++; if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); end
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", id_ready_o); end
        n_vec++; if (operand_a_o !== 32'd0 || ex_pc_o !== 32'd0) begin
            n_err++; $display("FAIL reset_fields: op_a %h pc %h want 0 0", operand_a_o, ex_pc_o);
        end
    endtask

    task automatic test_add();
        ex_ready_i = 1'b1;
        set_id(32'h40, 5'd1, 5'd2, 32'd10, 32'd5, 32'd0, 4'd0, 1'b0, 1'b0, 5'd3, 1'b1);
        step(1);
        id_valid_i = 1'b0;
        n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", ex_valid_o); end
        n_vec++; if (operand_a_o !== 32'd10) begin n_err++; $display("FAIL add_op_a: got %0d want 10", operand_a_o); end
        n_vec++; if (operand_b_o !== 32'd5) begin n_err++; $display("FAIL add_op_b: got %0d want 5", operand_b_o); end
        n_vec++; if (alu_op_o !== 4'd0) begin n_err++; $display("FAIL add_alu_op: got %0d want 0", alu_op_o); end
        n_vec++; if (ex_rd_addr_o !== 5'd3 || ex_rd_we_o !== 1'b1) begin
            n_err++; $display("FAIL add_rd: got %0d/%b want 3/1", ex_rd_addr_o, ex_rd_we_o);
        end
        step(1);
        n_vec++; if (ex_valid_o !== 1'b0 || ex_rd_we_o !== 1'b0) begin
            n_err++; $display("FAIL add_drain: valid %b rd_we %b want 0 0", ex_valid_o, ex_rd_we_o);
        end
    endtask

    task automatic test_bypass();
        ex_ready_i = 1'b1;
        // rs1=x4 stored 0x99, rs2=x6 stored 0x66, operand_b from imm 0x123.
        set_id(32'h80, 5'd4, 5'd6, 32'h99, 32'h66, 32'h123, 4'd1, 1'b0, 1'b1, 5'd5, 1'b1);
        step(1);
        id_valid_i = 1'b0;
        exm_rd_we_i = 1'b1; exm_rd_addr_i = 5'd4; exm_result_i = 32'h11;
        mwb_rd_we_i = 1'b1; mwb_rd_addr_i = 5'd4; mwb_result_i = 32'h22;
        #1;
        n_vec++; if (operand_a_o !== 32'h11) begin n_err++; $display("FAIL byp_exm_first: got %h want 11", operand_a_o); end
        n_vec++; if (ex_store_data_o !== 32'h66) begin n_err++; $display("FAIL byp_store_stored: got %h want 66", ex_store_data_o); end
        exm_rd_we_i = 1'b0;
        #1;
        n_vec++; if (operand_a_o !== 32'h22) begin n_err++; $display("FAIL byp_mwb: got %h want 22", operand_a_o); end
        mwb_rd_addr_i = 5'd6; mwb_result_i = 32'h33;
        #1;
        n_vec++; if (ex_store_data_o !== 32'h33 || operand_b_o !== 32'h123) begin
            n_err++; $display("FAIL byp_store_fwd: store %h op_b %h want 33 123", ex_store_data_o, operand_b_o);
        end
        n_vec++; if (operand_a_o !== 32'h99) begin n_err++; $display("FAIL byp_none: got %h want 99", operand_a_o); end
        mwb_rd_we_i = 1'b0;
        // x0 source with stale nonzero data and bypasses aimed at x0.
        set_id(32'h84, 5'd0, 5'd0, 32'h77, 32'h78, 32'd0, 4'd0, 1'b0, 1'b0, 5'd5, 1'b1);
        step(1);
        id_valid_i = 1'b0;
        exm_rd_we_i = 1'b1; exm_rd_addr_i = 5'd0; exm_result_i = 32'h11;
        mwb_rd_we_i = 1'b1; mwb_rd_addr_i = 5'd0; mwb_result_i = 32'h22;
        #1;
        n_vec++; if (operand_a_o !== 32'd0 || operand_b_o !== 32'd0) begin
            n_err++; $display("FAIL byp_x0: op_a %h op_b %h want 0 0", operand_a_o, operand_b_o);
        end
        exm_rd_we_i = 1'b0; mwb_rd_we_i = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        set_id(32'h100, 5'd1, 5'd7, 32'd1, 32'h07, 32'd0, 4'd0, 1'b0, 1'b0, 5'd9, 1'b1);
        step(1);
        // A different instruction waits at the input; it must not be taken during the hold.
        set_id(32'h104, 5'd2, 5'd3, 32'hAA, 32'hBB, 32'd0, 4'd2, 1'b0, 1'b0, 5'd12, 1'b1);
        ex_ready_i = 1'b0;
        mwb_rd_we_i = 1'b1; mwb_rd_addr_i = 5'd7; mwb_result_i = 32'h55;
        #1;
        n_vec++; if (id_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready0: got %b want 0", id_ready_o); end
        step(1);
        mwb_rd_we_i = 1'b0;
        step(1);
        n_vec++; if (id_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready1: got %b want 0", id_ready_o); end
        step(1);
        n_vec++; if (stall_cnt_o !== 16'd3) begin n_err++; $display("FAIL hold_stall: got %0d want 3", stall_cnt_o); end
        n_vec++; if (ex_pc_o !== 32'h100 || ex_rd_addr_o !== 5'd9 || operand_a_o !== 32'd1) begin
            n_err++; $display("FAIL hold_frozen: pc %h rd %0d op_a %h want 100 9 1", ex_pc_o, ex_rd_addr_o, operand_a_o);
        end
        n_vec++; if (operand_b_o !== 32'h55) begin n_err++; $display("FAIL hold_refresh: got %h want 55", operand_b_o); end
        id_valid_i = 1'b0; ex_ready_i = 1'b1;
        step(1);
        n_vec++; if (operand_b_o !== 32'h55 || ex_valid_o !== 1'b0 || stall_cnt_o !== 16'd3) begin
            n_err++; $display("FAIL hold_release: op_b %h valid %b stall %0d want 55 0 3", operand_b_o, ex_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_flush();
        ex_ready_i = 1'b1;
        set_id(32'h200, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 4'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        step(1);
        ex_ready_i = 1'b0; flush_i = 1'b1;
        #1;
        n_vec++; if (id_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", id_ready_o); end
        ex_ready_i = 1'b1;
        set_id(32'h204, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 4'd3, 1'b0, 1'b0, 5'd6, 1'b1);
        step(1);
        flush_i = 1'b0; id_valid_i = 1'b0;
        n_vec++; if (ex_valid_o !== 1'b0 || ex_rd_we_o !== 1'b0) begin
            n_err++; $display("FAIL flush_kill: valid %b rd_we %b want 0 0", ex_valid_o, ex_rd_we_o);
        end
    endtask

    task automatic test_slti();
        ex_ready_i = 1'b1;
        set_id(32'h300, 5'd2, 5'd0, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'd5, 1'b0, 1'b1, 5'd8, 1'b1);
        step(1);
        id_valid_i = 1'b0;
        n_vec++; if (operand_b_o !== 32'hFFFF_FFFF || operand_a_o !== 32'd7 || alu_op_o !== 4'd5) begin
            n_err++; $display("FAIL slti: op_a %h op_b %h alu %0d want 7 ffffffff 5", operand_a_o, operand_b_o, alu_op_o);
        end
    endtask

    task automatic test_back_to_back();
        ex_ready_i = 1'b1;
        set_id(32'h400, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 4'd4, 1'b0, 1'b0, 5'd10, 1'b1);
        step(1);
        set_id(32'h404, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 4'd7, 1'b1, 1'b0, 5'd11, 1'b0);
        #1;
        n_vec++; if (ex_pc_o !== 32'h400 || alu_op_o !== 4'd4 || ex_rd_addr_o !== 5'd10) begin
            n_err++; $display("FAIL b2b_first: pc %h alu %0d rd %0d want 400 4 10", ex_pc_o, alu_op_o, ex_rd_addr_o);
        end
        step(1);
        id_valid_i = 1'b0;
        n_vec++; if (operand_a_o !== 32'h404 || alu_op_o !== 4'd7 || ex_rd_we_o !== 1'b0 || ex_valid_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: op_a %h alu %0d rd_we %b valid %b want 404 7 0 1",
                              operand_a_o, alu_op_o, ex_rd_we_o, ex_valid_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(32'h500, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 4'd0, 1'b0, 1'b0, 5'd3, 1'b1);
        step(1);
        id_valid_i = 1'b0; ex_ready_i = 1'b0;
        step(5);
        n_vec++; if (s_stall_cnt !== 2'd3) begin n_err++; $display("FAIL sat_small: got %0d want 3", s_stall_cnt); end
        n_vec++; if (stall_cnt_o !== 16'd5) begin n_err++; $display("FAIL sat_wide: got %0d want 5", stall_cnt_o); end
        // Reset while still holding.
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        n_vec++; if (ex_valid_o !== 1'b0 || stall_cnt_o !== 16'd0 || s_stall_cnt !== 2'd0 || ex_pc_o !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_hold: valid %b stall %0d/%0d pc %h want 0 0/0 0",
                              ex_valid_o, stall_cnt_o, s_stall_cnt, ex_pc_o);
        end
        ex_ready_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; id_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
        id_pc_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0;
        id_imm_i = '0; id_alu_op_i = '0; id_src_a_pc_i = 1'b0; id_src_b_imm_i = 1'b0;
        id_rd_addr_i = '0; id_rd_we_i = 1'b0;
        exm_rd_addr_i = '0; exm_rd_we_i = 1'b0; exm_result_i = '0;
        mwb_rd_addr_i = '0; mwb_rd_we_i = 1'b0; mwb_result_i = '0;
        test_reset();
        test_add();
        test_bypass();
        test_hold();
        test_flush();
        test_slti();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
